// File: rtl/position_mover.sv
// Registered sprite position with a buffered turn request, advanced once per move tick.
// Arena edges either wrap (tunnel) or clamp per axis.
module position_mover #(
    parameter int unsigned COORD_W   = 10,
    parameter int unsigned SPEED_W   = 8,
    parameter int unsigned X_MIN     = 0,
    parameter int unsigned X_MAX     = 639,
    parameter int unsigned Y_MIN     = 0,
    parameter int unsigned Y_MAX     = 479,
    parameter int unsigned WRAP_X    = 1,
    parameter int unsigned WRAP_Y    = 0,
    parameter int unsigned START_X   = 320,
    parameter int unsigned START_Y   = 240,
    parameter int unsigned TURN_HOLD = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic [COORD_W-1:0] i_xpos_load,
    input  logic [COORD_W-1:0] i_ypos_load,
    input  logic               i_move_tick,
    input  logic [3:0]         i_legal_moves,
    input  logic [3:0]         i_dir_req,
    input  logic [SPEED_W-1:0] i_speed,
    output logic [COORD_W-1:0] o_xpos,
    output logic [COORD_W-1:0] o_ypos,
    output logic [3:0]         o_curr_dir,
    output logic               o_moving,
    output logic               o_blocked,
    output logic               o_wrapped
);

    localparam int unsigned AW     = COORD_W + 1;
    localparam int unsigned HOLD_W = (TURN_HOLD < 1) ? 1 : $clog2(TURN_HOLD + 1);
    localparam int unsigned X_SPAN = X_MAX - X_MIN + 1;
    localparam int unsigned Y_SPAN = Y_MAX - Y_MIN + 1;

    // Encoding chosen so moving/blocked are direct state register bits.
    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_MOVING  = 2'b01,
        S_BLOCKED = 2'b10
    } state_t;

    state_t              r_state,   w_state_nxt;
    logic [COORD_W-1:0]  r_xpos,    w_xpos_nxt;
    logic [COORD_W-1:0]  r_ypos,    w_ypos_nxt;
    logic [3:0]          r_dir,     w_dir_nxt;
    logic [3:0]          r_pending, w_pending_nxt;
    logic [HOLD_W-1:0]   r_hold,    w_hold_nxt;
    logic                r_wrapped, w_wrapped_nxt;

    logic [AW-1:0] w_spd, w_x, w_y;
    logic          w_x_lo, w_x_hi, w_y_lo, w_y_hi;
    logic          w_req_ok, w_pend_hit, w_dir_hit;
    logic [3:0]    w_step_dir;

    // Bound tests at one extra bit so pos+speed cannot overflow.
    assign w_spd  = AW'(i_speed);
    assign w_x    = AW'(r_xpos);
    assign w_y    = AW'(r_ypos);
    assign w_x_lo = w_x < (AW'(X_MIN) + w_spd);
    assign w_x_hi = (w_x + w_spd) > AW'(X_MAX);
    assign w_y_lo = w_y < (AW'(Y_MIN) + w_spd);
    assign w_y_hi = (w_y + w_spd) > AW'(Y_MAX);

    assign w_req_ok   = (i_dir_req != 4'd0) && ((i_dir_req & (i_dir_req - 4'd1)) == 4'd0);
    assign w_pend_hit = (r_pending & i_legal_moves) != 4'd0;
    assign w_dir_hit  = (r_dir & i_legal_moves) != 4'd0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_xpos    <= COORD_W'(START_X);
            r_ypos    <= COORD_W'(START_Y);
            r_dir     <= 4'd0;
            r_pending <= 4'd0;
            r_hold    <= '0;
            r_wrapped <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_xpos    <= w_xpos_nxt;
            r_ypos    <= w_ypos_nxt;
            r_dir     <= w_dir_nxt;
            r_pending <= w_pending_nxt;
            r_hold    <= w_hold_nxt;
            r_wrapped <= w_wrapped_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_xpos_nxt    = r_xpos;
        w_ypos_nxt    = r_ypos;
        w_dir_nxt     = r_dir;
        w_pending_nxt = r_pending;
        w_hold_nxt    = r_hold;
        w_wrapped_nxt = 1'b0;
        w_step_dir    = 4'd0;

        if (i_load) begin
            w_state_nxt   = S_IDLE;
            w_xpos_nxt    = i_xpos_load;
            w_ypos_nxt    = i_ypos_load;
            w_dir_nxt     = 4'd0;
            w_pending_nxt = 4'd0;
            w_hold_nxt    = '0;
        end else begin
            if (i_move_tick) begin
                if (w_pend_hit) begin
                    w_dir_nxt     = r_pending;
                    w_pending_nxt = 4'd0;
                    w_hold_nxt    = '0;
                    w_step_dir    = r_pending;
                end else begin
                    if (w_dir_hit) begin
                        w_step_dir = r_dir;
                    end else begin
                        w_state_nxt = (r_dir != 4'd0) ? S_BLOCKED : S_IDLE;
                    end
                    // A buffered turn ages by one tick whenever it is not taken.
                    if (r_pending != 4'd0) begin
                        if (r_hold <= HOLD_W'(1)) begin
                            w_pending_nxt = 4'd0;
                            w_hold_nxt    = '0;
                        end else begin
                            w_hold_nxt = r_hold - HOLD_W'(1);
                        end
                    end
                end

                if (w_step_dir != 4'd0) begin
                    w_state_nxt = S_MOVING;
                    if (w_step_dir[0]) begin
                        if (!w_x_lo) begin
                            w_xpos_nxt = COORD_W'(w_x - w_spd);
                        end else if (WRAP_X != 0) begin
                            w_xpos_nxt    = COORD_W'(w_x + AW'(X_SPAN) - w_spd);
                            w_wrapped_nxt = 1'b1;
                        end else begin
                            w_xpos_nxt  = COORD_W'(X_MIN);
                            w_state_nxt = S_BLOCKED;
                        end
                    end else if (w_step_dir[1]) begin
                        if (!w_x_hi) begin
                            w_xpos_nxt = COORD_W'(w_x + w_spd);
                        end else if (WRAP_X != 0) begin
                            w_xpos_nxt    = COORD_W'(w_x + w_spd - AW'(X_SPAN));
                            w_wrapped_nxt = 1'b1;
                        end else begin
                            w_xpos_nxt  = COORD_W'(X_MAX);
                            w_state_nxt = S_BLOCKED;
                        end
                    end else if (w_step_dir[2]) begin
                        if (!w_y_lo) begin
                            w_ypos_nxt = COORD_W'(w_y - w_spd);
                        end else if (WRAP_Y != 0) begin
                            w_ypos_nxt    = COORD_W'(w_y + AW'(Y_SPAN) - w_spd);
                            w_wrapped_nxt = 1'b1;
                        end else begin
                            w_ypos_nxt  = COORD_W'(Y_MIN);
                            w_state_nxt = S_BLOCKED;
                        end
                    end else begin
                        if (!w_y_hi) begin
                            w_ypos_nxt = COORD_W'(w_y + w_spd);
                        end else if (WRAP_Y != 0) begin
                            w_ypos_nxt    = COORD_W'(w_y + w_spd - AW'(Y_SPAN));
                            w_wrapped_nxt = 1'b1;
                        end else begin
                            w_ypos_nxt  = COORD_W'(Y_MAX);
                            w_state_nxt = S_BLOCKED;
                        end
                    end
                end
            end

            // New request overrides; a tick this cycle already used the old one.
            if (w_req_ok) begin
                w_pending_nxt = i_dir_req;
                w_hold_nxt    = HOLD_W'(TURN_HOLD);
            end
        end
    end

    assign o_xpos     = r_xpos;
    assign o_ypos     = r_ypos;
    assign o_curr_dir = r_dir;
    assign o_moving   = r_state[0];
    assign o_blocked  = r_state[1];
    assign o_wrapped  = r_wrapped;

endmodule

// File: tb/tb_position_mover.sv
// Bench for position_mover: expected outputs queued with each stimulus cycle, compared after the edge.
module tb_position_mover;

    logic       clk = 1'b0;
    logic       rst, load, move_tick;
    logic [9:0] xpos_load, ypos_load;
    logic [3:0] legal_moves, dir_req;
    logic [7:0] speed;

    logic [9:0] a_x, a_y, b_x, b_y;
    logic [3:0] a_dir, b_dir;
    logic       a_mv, a_bl, a_wr, b_mv, b_bl, b_wr;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit sel;
        int x, y, dir, mv, bl, wr;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    position_mover dut (
        .i_clk(clk), .i_rst(rst), .i_load(load),
        .i_xpos_load(xpos_load), .i_ypos_load(ypos_load),
        .i_move_tick(move_tick), .i_legal_moves(legal_moves),
        .i_dir_req(dir_req), .i_speed(speed),
        .o_xpos(a_x), .o_ypos(a_y), .o_curr_dir(a_dir),
        .o_moving(a_mv), .o_blocked(a_bl), .o_wrapped(a_wr)
    );

    position_mover #(.TURN_HOLD(2)) dut_h2 (
        .i_clk(clk), .i_rst(rst), .i_load(load),
        .i_xpos_load(xpos_load), .i_ypos_load(ypos_load),
        .i_move_tick(move_tick), .i_legal_moves(legal_moves),
        .i_dir_req(dir_req), .i_speed(speed),
        .o_xpos(b_x), .o_ypos(b_y), .o_curr_dir(b_dir),
        .o_moving(b_mv), .o_blocked(b_bl), .o_wrapped(b_wr)
    );

    task automatic chk(input string tag, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic drv(input bit r, input bit ld, input int lx, input int ly,
                       input bit tk, input logic [3:0] lg, input logic [3:0] rq, input int sp);
        rst = r; load = ld; xpos_load = 10'(lx); ypos_load = 10'(ly);
        move_tick = tk; legal_moves = lg; dir_req = rq; speed = 8'(sp);
    endtask

    task automatic expect_out(input string tag, input bit sel, input int x, input int y,
                              input int dir, input int mv, input int bl, input int wr);
        exp_t e;
        e.sel = sel; e.x = x; e.y = y; e.dir = dir; e.mv = mv; e.bl = bl; e.wr = wr;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Load cycle: position set, everything else idle.
    task automatic ld_pos(input int x, input int y);
        drv(0, 1, x, y, 0, 4'hF, 4'd0, 4);
        expect_out("load", 0, x, y, 0, 0, 0, 0);
        step();
    endtask

    task automatic req_only(input logic [3:0] rq, input int x, input int y);
        drv(0, 0, 0, 0, 0, 4'hF, rq, 4);
        expect_out("req_only", 0, x, y, 0, 0, 0, 0);
        step();
    endtask

    // Scoreboard: everything queued before an edge is checked just after it.
    initial begin
        forever begin
            exp_t  e;
            string t;
            @(posedge clk);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                if (e.sel == 1'b0) begin
                    chk({t, ".x"}, int'(a_x), e.x);
                    chk({t, ".y"}, int'(a_y), e.y);
                    chk({t, ".dir"}, int'(a_dir), e.dir);
                    chk({t, ".moving"}, int'(a_mv), e.mv);
                    chk({t, ".blocked"}, int'(a_bl), e.bl);
                    chk({t, ".wrapped"}, int'(a_wr), e.wr);
                end else begin
                    chk({t, ".x"}, int'(b_x), e.x);
                    chk({t, ".y"}, int'(b_y), e.y);
                    chk({t, ".dir"}, int'(b_dir), e.dir);
                    chk({t, ".moving"}, int'(b_mv), e.mv);
                    chk({t, ".blocked"}, int'(b_bl), e.bl);
                    chk({t, ".wrapped"}, int'(b_wr), e.wr);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        drv(1, 0, 0, 0, 0, 4'hF, 4'd0, 4);
        @(negedge clk);

        expect_out("reset", 0, 320, 240, 0, 0, 0, 0);
        expect_out("reset_h2", 1, 320, 240, 0, 0, 0, 0);
        step();

        drv(0, 0, 0, 0, 1, 4'hF, 4'd0, 4);
        expect_out("idle_tick", 0, 320, 240, 0, 0, 0, 0);
        step();

        // Buffered right turn while only left is legal.
        req_only(4'b0010, 320, 240);
        for (int i = 0; i < 3; i++) begin
            drv(0, 0, 0, 0, 1, 4'b0001, 4'd0, 4);
            expect_out("held", 0, 320, 240, 0, 0, 0, 0);
            expect_out("held_h2", 1, 320, 240, 0, 0, 0, 0);
            step();
        end
        drv(0, 0, 0, 0, 1, 4'b0011, 4'd0, 4);
        expect_out("turn", 0, 324, 240, 2, 1, 0, 0);
        expect_out("expired_h2", 1, 320, 240, 0, 0, 0, 0);
        step();

        // Load beats a coincident tick and request.
        drv(0, 1, 100, 240, 1, 4'hF, 4'b0001, 4);
        expect_out("load_prio", 0, 100, 240, 0, 0, 0, 0);
        step();
        drv(0, 0, 0, 0, 1, 4'hF, 4'd0, 4);
        expect_out("pend_empty", 0, 100, 240, 0, 0, 0, 0);
        step();

        // Blocked and recovery.
        req_only(4'b0001, 100, 240);
        drv(0, 0, 0, 0, 1, 4'b0001, 4'd0, 4);
        expect_out("go_left", 0, 96, 240, 1, 1, 0, 0);
        step();
        drv(0, 0, 0, 0, 1, 4'b0000, 4'd0, 4);
        expect_out("blocked", 0, 96, 240, 1, 0, 1, 0);
        step();
        drv(0, 0, 0, 0, 1, 4'b0001, 4'd0, 4);
        expect_out("unblock", 0, 92, 240, 1, 1, 0, 0);
        step();

        // Horizontal wrap both ways, plus exact reach of X_MIN.
        ld_pos(2, 240);
        req_only(4'b0001, 2, 240);
        drv(0, 0, 0, 0, 1, 4'hF, 4'd0, 4);
        expect_out("wrap_l", 0, 638, 240, 1, 1, 0, 1);
        step();
        drv(0, 0, 0, 0, 0, 4'hF, 4'd0, 4);
        expect_out("wrap_pulse_l", 0, 638, 240, 1, 1, 0, 0);
        step();

        ld_pos(637, 240);
        req_only(4'b0010, 637, 240);
        drv(0, 0, 0, 0, 1, 4'hF, 4'd0, 4);
        expect_out("wrap_r", 0, 1, 240, 2, 1, 0, 1);
        step();
        drv(0, 0, 0, 0, 0, 4'hF, 4'd0, 4);
        expect_out("wrap_pulse_r", 0, 1, 240, 2, 1, 0, 0);
        step();

        ld_pos(4, 240);
        req_only(4'b0001, 4, 240);
        drv(0, 0, 0, 0, 1, 4'hF, 4'd0, 4);
        expect_out("exact_min", 0, 0, 240, 1, 1, 0, 0);
        step();

        // Vertical clamp vs exact reach of Y_MAX.
        ld_pos(100, 477);
        req_only(4'b1000, 100, 477);
        drv(0, 0, 0, 0, 1, 4'hF, 4'd0, 4);
        expect_out("clamp_y", 0, 100, 479, 8, 0, 1, 0);
        step();
        ld_pos(100, 475);
        req_only(4'b1000, 100, 475);
        drv(0, 0, 0, 0, 1, 4'hF, 4'd0, 4);
        expect_out("reach_max", 0, 100, 479, 8, 1, 0, 0);
        step();

        // Request coincident with a tick applies one tick later.
        ld_pos(100, 200);
        req_only(4'b1000, 100, 200);
        drv(0, 0, 0, 0, 1, 4'hF, 4'd0, 4);
        expect_out("down", 0, 100, 204, 8, 1, 0, 0);
        step();
        drv(0, 0, 0, 0, 1, 4'hF, 4'b0010, 4);
        expect_out("late_req", 0, 100, 208, 8, 1, 0, 0);
        step();
        drv(0, 0, 0, 0, 1, 4'hF, 4'd0, 4);
        expect_out("turn_r", 0, 104, 208, 2, 1, 0, 0);
        step();

        // Multi-hot request ignored; zero speed still counts as moving.
        drv(0, 0, 0, 0, 1, 4'hF, 4'b0011, 4);
        expect_out("multi_hot", 0, 108, 208, 2, 1, 0, 0);
        step();
        drv(0, 0, 0, 0, 1, 4'hF, 4'd0, 4);
        expect_out("after_multi", 0, 112, 208, 2, 1, 0, 0);
        step();
        drv(0, 0, 0, 0, 1, 4'hF, 4'd0, 0);
        expect_out("speed0", 0, 112, 208, 2, 1, 0, 0);
        step();

        // Reset mid-motion.
        drv(1, 0, 0, 0, 1, 4'hF, 4'b0001, 4);
        expect_out("rst_mid", 0, 320, 240, 0, 0, 0, 0);
        step();
        drv(0, 0, 0, 0, 1, 4'hF, 4'd0, 4);
        expect_out("post_rst", 0, 320, 240, 0, 0, 0, 0);
        step();

        drv(0, 0, 0, 0, 0, 4'hF, 4'd0, 4);
        step();
        step();
        chk("drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
